// File: rtl/pcard_pack_pkg.sv
// pcard_pack_pkg: shared FSM state type, default sizes and FIFO level width helper
package pcard_pack_pkg;
   typedef enum logic [1:0] {IDLE, OUT_A, OUT_B} state_e;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_FIFO_DEPTH = 16;
   function automatic int lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
   localparam int LVL_W = lvl_w(DEF_FIFO_DEPTH);
endpackage

// File: rtl/pcard_pack_fifo.sv
// pcard_pack_fifo: synchronous FIFO with occupancy-count full/empty and level output
module pcard_pack_fifo
   import pcard_pack_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n_i,
   input  logic                     push_i,
   input  logic [DATA_W-1:0]        din_i,
   input  logic                     pop_i,
   output logic [DATA_W-1:0]        dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [lvl_w(DEPTH)-1:0]  level_o
);
   localparam int LW = lvl_w(DEPTH);
   localparam int AW = LW - 1;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [LW-1:0] cnt_q;
   logic do_push, do_pop;
   assign full_o  = cnt_q == LW'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign level_o = cnt_q;
   assign dout_o  = mem_q[rd_q];
   // a paired push+pop is accepted even when full or empty, keeping the count unchanged
   assign do_push = push_i && (!full_o || pop_i);
   assign do_pop  = pop_i && (!empty_o || push_i);
   always_ff @(posedge clk) begin
      if (!rst_n_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + LW'(do_push) - LW'(do_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end
endmodule

// File: rtl/pcard_pack.sv
// pcard_pack: buffers two AXI-Stream channels and emits them strictly interleaved A,B,A,B.
// Debug outputs are live only when PCARD_PACK_DEBUG_EN is defined, otherwise tied to 0.
module pcard_pack
   import pcard_pack_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic              axis_aclk,
   input  logic              axis_a_aresetn_i,
   input  logic              axis_b_aresetn_i,
   output logic              axis_aresetn_o,
   input  logic              s_axis_a_tvalid,
   output logic              s_axis_a_tready,
   input  logic [DATA_W-1:0] s_axis_a_tdata,
   input  logic              s_axis_b_tvalid,
   output logic              s_axis_b_tready,
   input  logic [DATA_W-1:0] s_axis_b_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic [DATA_W-1:0] m_axis_tdata,
   input  logic              adc_start,
   output logic [31:0]       debug_data1,
   output logic [31:0]       debug_data2,
   output logic              debug_sig,
   output logic              debug_sig1
);
   localparam int LW = lvl_w(FIFO_DEPTH);
   logic rst_n, start, pop_a, pop_b;
   logic full_a, full_b, empty_a, empty_b;
   logic [DATA_W-1:0] head_a, head_b;
   logic [LW-1:0] lvl_a, lvl_b;
   state_e state_q, state_d;
   logic [DATA_W-1:0] tdata_q, tdata_d;
   logic tvalid_q, tvalid_d, aresetn_q;
   assign rst_n           = axis_a_aresetn_i && axis_b_aresetn_i;
   assign s_axis_a_tready = rst_n && adc_start && !full_a;
   assign s_axis_b_tready = rst_n && adc_start && !full_b;
   assign start           = adc_start && !empty_a && !empty_b;
   assign m_axis_tvalid   = tvalid_q;
   assign m_axis_tdata    = tdata_q;
   assign axis_aresetn_o  = aresetn_q && rst_n;
   pcard_pack_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_a (
      .clk(axis_aclk), .rst_n_i(rst_n),
      .push_i(s_axis_a_tvalid && s_axis_a_tready), .din_i(s_axis_a_tdata),
      .pop_i(pop_a), .dout_o(head_a), .full_o(full_a), .empty_o(empty_a), .level_o(lvl_a)
   );
   pcard_pack_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_b (
      .clk(axis_aclk), .rst_n_i(rst_n),
      .push_i(s_axis_b_tvalid && s_axis_b_tready), .din_i(s_axis_b_tdata),
      .pop_i(pop_b), .dout_o(head_b), .full_o(full_b), .empty_o(empty_b), .level_o(lvl_b)
   );
   // a pair only starts with both heads present, so OUT_A can always fetch B
   always_comb begin
      state_d  = state_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      pop_a    = 1'b0;
      pop_b    = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d  = OUT_A;
            tdata_d  = head_a;
            tvalid_d = 1'b1;
            pop_a    = 1'b1;
         end
         OUT_A: if (m_axis_tready) begin
            state_d = OUT_B;
            tdata_d = head_b;
            pop_b   = 1'b1;
         end
         OUT_B: if (m_axis_tready) begin
            state_d  = start ? OUT_A : IDLE;
            tdata_d  = start ? head_a : tdata_q;
            tvalid_d = start;
            pop_a    = start;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge axis_aclk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         tdata_q   <= '0;
         tvalid_q  <= 1'b0;
         aresetn_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         tdata_q   <= tdata_d;
         tvalid_q  <= tvalid_d;
         aresetn_q <= 1'b1;
      end
   end
`ifdef PCARD_PACK_DEBUG_EN
   logic [31:0] pairs_q;
   logic imb_q;
   always_ff @(posedge axis_aclk) begin
      if (!rst_n) begin
         pairs_q <= '0;
         imb_q   <= 1'b0;
      end else begin
         if (state_q == OUT_B && m_axis_tready) pairs_q <= pairs_q + 1'b1;
         if ((full_a && empty_b) || (full_b && empty_a)) imb_q <= 1'b1;
      end
   end
   assign debug_data1 = pairs_q;
   assign debug_data2 = {16'(lvl_b), 16'(lvl_a)};
   assign debug_sig   = state_q != IDLE;
   assign debug_sig1  = imb_q;
`else
   logic unused_lvl;
   assign unused_lvl  = ^{lvl_a, lvl_b};
   assign debug_data1 = '0;
   assign debug_data2 = '0;
   assign debug_sig   = 1'b0;
   assign debug_sig1  = 1'b0;
`endif
endmodule

// File: tb/tb_pcard_pack.sv
// tb_pcard_pack: directed self-checking bench for pcard_pack
module tb_pcard_pack;
`ifdef PCARD_PACK_DEBUG_EN
   localparam bit DBG = 1'b1;
`else
   localparam bit DBG = 1'b0;
`endif
   logic clk = 1'b0;
   logic ra, rb, rsto, start;
   logic a_v, a_r, b_v, b_r, m_v, m_r;
   logic [31:0] a_d, b_d, m_d, d1, d2;
   logic ds, ds1;
   int vectors = 0;
   int miscompares = 0;
   always #5 clk = ~clk;
   pcard_pack dut (
      .axis_aclk(clk), .axis_a_aresetn_i(ra), .axis_b_aresetn_i(rb), .axis_aresetn_o(rsto),
      .s_axis_a_tvalid(a_v), .s_axis_a_tready(a_r), .s_axis_a_tdata(a_d),
      .s_axis_b_tvalid(b_v), .s_axis_b_tready(b_r), .s_axis_b_tdata(b_d),
      .m_axis_tvalid(m_v), .m_axis_tready(m_r), .m_axis_tdata(m_d),
      .adc_start(start), .debug_data1(d1), .debug_data2(d2), .debug_sig(ds), .debug_sig1(ds1)
   );
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   initial begin
      ra = 0; rb = 0; start = 1; m_r = 1;
      a_v = 0; b_v = 0; a_d = 0; b_d = 0;
      repeat (5) step();
      chk("rst_aresetn_o", rsto, 0);
      chk("rst_tvalid", m_v, 0);
      chk("rst_tdata", m_d, 0);
      chk("rst_a_tready", a_r, 0);
      chk("rst_b_tready", b_r, 0);
      chk("rst_dbg", {d1 | d2, 30'd0, ds, ds1}, 0);
      ra = 1; rb = 1;
      #1;
      chk("rel_aresetn_o_lag", rsto, 0);
      chk("rel_a_tready", a_r, 1);
      step();
      chk("rel_aresetn_o", rsto, 1);
      for (int c = 1; c <= 10; c++) begin
         a_v = c <= 4; b_v = c <= 4;
         a_d = 32'(32'hA0 + c - 1); b_d = 32'(32'hB0 + c - 1);
         step();
         if (c >= 2 && c <= 9) begin
            chk("il_valid", m_v, 1);
            chk("il_data", m_d, (c % 2 == 0) ? 32'(32'hA0 + (c - 2) / 2) : 32'(32'hB0 + (c - 2) / 2));
         end
      end
      chk("il_idle", m_v, 0);
      chk("il_pairs", d1, DBG ? 32'd4 : 32'd0);
      chk("il_busy", ds, 0);
      m_r = 0; a_v = 1; b_v = 1; a_d = 32'h10; b_d = 32'h20;
      step();
      a_d = 32'h11; b_d = 32'h21;
      step();
      a_v = 0; b_v = 0;
      chk("bp_a0", m_d, 32'h10);
      chk("bp_v", m_v, 1);
      chk("bp_busy", ds, DBG);
      step();
      chk("bp_stall_a", m_d, 32'h10);
      m_r = 1; step();
      chk("bp_b0", m_d, 32'h20);
      m_r = 0; step();
      chk("bp_stall_b", m_d, 32'h20);
      m_r = 1; step();
      chk("bp_a1", m_d, 32'h11);
      step();
      chk("bp_b1", m_d, 32'h21);
      m_r = 0; step();
      chk("bp_stall_b1", {m_v, m_d}, {1'b1, 32'h21});
      m_r = 1; step();
      chk("bp_idle", m_v, 0);
      m_r = 0; a_v = 1; b_v = 1;
      for (int i = 0; i <= 16; i++) begin
         a_d = 32'(32'h100 + i); b_d = 32'(32'h200 + i);
         step();
         if (i == 15) begin
            chk("full_b_tready", b_r, 0);
            chk("full_a_open", a_r, 1);
         end
      end
      chk("full_a_tready", a_r, 0);
      a_v = 0; b_v = 0;
      chk("full_head", m_d, 32'h100);
      m_r = 1;
      for (int k = 1; k <= 31; k++) begin
         step();
         chk("drain_data", m_d, (k % 2 == 1) ? 32'(32'h200 + k / 2) : 32'(32'h100 + k / 2));
      end
      step();
      chk("drain_idle", m_v, 0);
      chk("drain_pairs", d1, DBG ? 32'd22 : 32'd0);
      chk("drain_levels", d2, DBG ? 32'h0000_0001 : 32'd0);
      a_v = 1; b_v = 1; a_d = 32'h30; b_d = 32'h40;
      step();
      a_v = 0; b_v = 0;
      step();
      chk("mr_leftover_a", m_d, 32'h110);
      rb = 0;
      #1;
      chk("mr_a_tready", a_r, 0);
      chk("mr_b_tready", b_r, 0);
      chk("mr_aresetn_o", rsto, 0);
      step();
      chk("mr_tvalid", m_v, 0);
      chk("mr_tdata", m_d, 0);
      chk("mr_dbg", d1 | d2, 0);
      rb = 1;
      step();
      chk("mr_rel", rsto, 1);
      a_v = 1; b_v = 1; a_d = 32'h50; b_d = 32'h60;
      step();
      a_v = 0; b_v = 0;
      step();
      chk("mr_resume_a", m_d, 32'h50);
      step();
      chk("mr_resume_b", m_d, 32'h60);
      step();
      chk("mr_resume_idle", m_v, 0);
      chk("mr_pairs", d1, DBG ? 32'd1 : 32'd0);
      a_v = 1;
      for (int i = 0; i < 20; i++) begin
         a_d = 32'(32'h70 + i);
         step();
         if (i == 14) chk("imb_a_open", a_r, 1);
         if (i == 15) chk("imb_a_full", a_r, 0);
      end
      chk("imb_no_out", m_v, 0);
      chk("imb_b_tready", b_r, 1);
      chk("imb_flag", ds1, DBG);
      chk("imb_levels", d2, DBG ? 32'h0000_0010 : 32'd0);
      a_v = 0;
      for (int e = 1; e <= 34; e++) begin
         b_v = e <= 16; b_d = 32'(32'h90 + e - 1);
         step();
         if (e >= 2 && e <= 33)
            chk("imb_drain", m_d, (e % 2 == 0) ? 32'(32'h70 + (e - 2) / 2) : 32'(32'h90 + (e - 2) / 2));
      end
      b_v = 0;
      chk("imb_drain_idle", m_v, 0);
      chk("imb_sticky", ds1, DBG);
      a_v = 1; b_v = 1; a_d = 32'hC0; b_d = 32'hD0;
      step();
      a_d = 32'hC1; b_d = 32'hD1;
      step();
      a_v = 0; b_v = 0;
      chk("stop_a", m_d, 32'hC0);
      start = 0;
      #1;
      chk("stop_a_tready", a_r, 0);
      chk("stop_b_tready", b_r, 0);
      step();
      chk("stop_b_emitted", {m_v, m_d}, {1'b1, 32'hD0});
      step();
      chk("stop_idle", m_v, 0);
      chk("stop_busy", ds, 0);
      chk("stop_retained", d2, DBG ? 32'h0001_0001 : 32'd0);
      step();
      chk("stop_no_new", m_v, 0);
      start = 1;
      step();
      chk("restart_a", m_d, 32'hC1);
      step();
      chk("restart_b", m_d, 32'hD1);
      step();
      chk("restart_idle", m_v, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
